// File: rtl/bsg_link_iddr_reassembler_pkg.sv
// Definitions shared by the link PHY transmit and receive sides: phase encoding
// and the order in which the two halves of a word cross the link.
package bsg_link_pkg;

    typedef enum logic {
        e_phase_low  = 1'b0,
        e_phase_high = 1'b1
    } bsg_link_phase_e;

    localparam int bsg_link_low_first_lp = 1;

endpackage

// File: rtl/bsg_link_iddr_reassembler_two_fifo.sv
// Two-entry FIFO holding reassembled words; the head entry is driven straight from storage.
// Storage is reset so the head never shows X.
module bsg_link_rx_two_fifo #(
    parameter int width_p = 32
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic               i_enq,
    input  logic               i_deq,
    input  logic [width_p-1:0] i_data,
    output logic [width_p-1:0] o_data,
    output logic [1:0]         o_count,
    output logic               o_full
);

    logic [width_p-1:0] r_mem [2];
    logic               r_rd_ptr;
    logic               r_wr_ptr;
    logic [1:0]         r_count;
    logic               w_deq;
    logic               w_enq;

    // A dequeue on an empty FIFO is ignored; a full FIFO still accepts when the head leaves.
    assign w_deq = i_deq && (r_count != 2'd0);
    assign w_enq = i_enq && ((r_count != 2'd2) || w_deq);

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_rd_ptr <= 1'b0;
            r_wr_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_enq) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_deq) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            if (w_enq && !w_deq) begin
                r_count <= r_count + 2'd1;
            end else if (w_deq && !w_enq) begin
                r_count <= r_count - 2'd1;
            end
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == 2'd2);

endmodule

// File: rtl/bsg_link_iddr_reassembler.sv
// Pairs half-width link beats (low half first) back into full words and buffers
// them behind a valid/yumi interface, flagging words lost to a full buffer.
module bsg_link_iddr_reassembler
    import bsg_link_pkg::*;
#(
    parameter int width_p = 32
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic                 valid_i,
    input  logic [width_p/2-1:0] data_i,
    input  logic                 realign_i,
    output logic                 valid_o,
    output logic [width_p-1:0]   data_o,
    input  logic                 yumi_i,
    output logic                 overflow_o,
    output logic                 phase_o
);

    localparam int half_lp = width_p / 2;

    bsg_link_phase_e     r_phase;
    logic [half_lp-1:0]  r_low;
    logic                r_overflow;

    logic                w_complete;
    logic                w_yumi;
    logic                w_full;
    logic                w_accept;
    logic [1:0]          w_count;
    logic [width_p-1:0]  w_word;

    assign w_word     = (bsg_link_low_first_lp != 0) ? {data_i, r_low} : {r_low, data_i};
    assign w_complete = valid_i && !realign_i && (r_phase == e_phase_high);
    assign w_yumi     = yumi_i && (w_count != 2'd0);
    assign w_accept   = w_complete && (!w_full || w_yumi);

    // Realign wins over any beat in the same cycle and drops the held low half.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_phase    <= e_phase_low;
            r_low      <= '0;
            r_overflow <= 1'b0;
        end else if (realign_i) begin
            r_phase <= e_phase_low;
            r_low   <= '0;
        end else if (valid_i) begin
            if (r_phase == e_phase_low) begin
                r_low   <= data_i;
                r_phase <= e_phase_high;
            end else begin
                r_phase <= e_phase_low;
                if (!w_accept) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    bsg_link_rx_two_fifo #(
        .width_p (width_p)
    ) u_fifo (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .i_enq     (w_accept),
        .i_deq     (w_yumi),
        .i_data    (w_word),
        .o_data    (data_o),
        .o_count   (w_count),
        .o_full    (w_full)
    );

    assign valid_o    = (w_count != 2'd0);
    assign overflow_o = r_overflow;
    assign phase_o    = (r_phase == e_phase_high);

endmodule

// File: tb/tb_bsg_link_iddr_reassembler.sv
// Directed and random stimulus for the link reassembler, checked against a
// queue-based model of word pairing, buffering and overflow.
module tb_bsg_link_iddr_reassembler;

    localparam int W = 32;
    localparam int H = W / 2;

    logic          clk;
    logic          resetN;
    logic          validIn;
    logic [H-1:0]  dataIn;
    logic          realignIn;
    logic          validOut;
    logic [W-1:0]  dataOut;
    logic          yumiIn;
    logic          overflowOut;
    logic          phaseOut;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] mQueue [$];
    logic         mPhase;
    logic [H-1:0] mLow;
    logic         mOverflow;

    bsg_link_iddr_reassembler #(.width_p(W)) dut (
        .clk_i      (clk),
        .reset_n_i  (resetN),
        .valid_i    (validIn),
        .data_i     (dataIn),
        .realign_i  (realignIn),
        .valid_o    (validOut),
        .data_o     (dataOut),
        .yumi_i     (yumiIn),
        .overflow_o (overflowOut),
        .phase_o    (phaseOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The consumer may only take a word the DUT is actually presenting.
    always @(negedge clk) begin
        if (resetN && yumiIn) begin
            checks++;
            assert (validOut === 1'b1) else begin
                errors++;
                $error("[TB] FAIL yumi_legal observed valid_o=%b expected 1", validOut);
            end
        end
    end

    task automatic modelReset();
        mQueue.delete();
        mPhase    = 1'b0;
        mLow      = '0;
        mOverflow = 1'b0;
    endtask

    // Model: a beat pair becomes a word; up to two words wait; a third is lost.
    task automatic modelStep(input logic v, input logic [H-1:0] d, input logic ra, input logic y);
        logic         take;
        logic         push;
        int           size;
        logic [W-1:0] word;
        take = y && (mQueue.size() > 0);
        push = 1'b0;
        size = mQueue.size();
        word = '0;
        if (ra) begin
            mPhase = 1'b0;
            mLow   = '0;
        end else if (v) begin
            if (!mPhase) begin
                mLow   = d;
                mPhase = 1'b1;
            end else begin
                mPhase = 1'b0;
                word   = {d, mLow};
                if (size < 2 || take) push = 1'b1;
                else mOverflow = 1'b1;
            end
        end
        if (take) void'(mQueue.pop_front());
        if (push) mQueue.push_back(word);
    endtask

    task automatic applyStimulus(input logic v, input logic [H-1:0] d, input logic ra, input logic take);
        validIn   = v;
        dataIn    = d;
        realignIn = ra;
        yumiIn    = take && (mQueue.size() > 0);
        modelStep(v, d, ra, yumiIn);
        @(posedge clk);
        #1;
    endtask

    task automatic checkValue(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic expValid;
        expValid = (mQueue.size() != 0);
        checks++;
        assert (validOut === expValid) else begin
            errors++;
            $error("[TB] FAIL %s.valid observed %b expected %b", tag, validOut, expValid);
        end
        if (expValid) begin
            checks++;
            assert (dataOut === mQueue[0]) else begin
                errors++;
                $error("[TB] FAIL %s.data observed %h expected %h", tag, dataOut, mQueue[0]);
            end
        end
        checks++;
        assert (overflowOut === mOverflow) else begin
            errors++;
            $error("[TB] FAIL %s.overflow observed %b expected %b", tag, overflowOut, mOverflow);
        end
        checks++;
        assert (phaseOut === mPhase) else begin
            errors++;
            $error("[TB] FAIL %s.phase observed %b expected %b", tag, phaseOut, mPhase);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b1);
            checkOutput("drain");
        end
    endtask

    initial begin
        logic         v;
        logic [H-1:0] d;
        logic         ra;
        logic         y;

        resetN    = 1'b0;
        validIn   = 1'b0;
        dataIn    = '0;
        realignIn = 1'b0;
        yumiIn    = 1'b0;
        modelReset();
        #1;
        checkOutput("reset_init");
        @(posedge clk);
        @(posedge clk);
        #1;
        resetN = 1'b1;
        checkOutput("post_reset");

        $display("[TB] back-to-back");
        applyStimulus(1'b1, 16'h1111, 1'b0, 1'b1);
        checkOutput("b2b1");
        applyStimulus(1'b1, 16'h2222, 1'b0, 1'b1);
        checkOutput("b2b2");
        checkValue("b2b_word0", dataOut, 32'h22221111);
        applyStimulus(1'b1, 16'h3333, 1'b0, 1'b1);
        checkOutput("b2b3");
        applyStimulus(1'b1, 16'h4444, 1'b0, 1'b1);
        checkOutput("b2b4");
        checkValue("b2b_word1", dataOut, 32'h44443333);
        checkValue("b2b_overflow", {31'd0, overflowOut}, 32'd0);
        drain();

        $display("[TB] gap");
        applyStimulus(1'b1, 16'hAAAA, 1'b0, 1'b0);
        checkOutput("gap_low");
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, '0, 1'b0, 1'b0);
            checkOutput("gap_idle");
        end
        applyStimulus(1'b1, 16'hBBBB, 1'b0, 1'b0);
        checkOutput("gap_high");
        checkValue("gap_word", dataOut, 32'hBBBBAAAA);
        drain();

        $display("[TB] full plus yumi");
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0);
        checkOutput("fy_full");
        applyStimulus(1'b1, 16'h0006, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0007, 1'b0, 1'b1);
        checkOutput("fy_enq");
        checkValue("fy_no_overflow", {31'd0, overflowOut}, 32'd0);
        checkValue("fy_head", dataOut, 32'h00030002);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("fy_drain1");
        checkValue("fy_second", dataOut, 32'h00070006);
        drain();

        $display("[TB] overflow");
        applyStimulus(1'b1, 16'h0000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0001, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0002, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0003, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0004, 1'b0, 1'b0);
        checkValue("ovf_before", {31'd0, overflowOut}, 32'd0);
        applyStimulus(1'b1, 16'h0005, 1'b0, 1'b0);
        checkOutput("ovf_third");
        checkValue("ovf_flag", {31'd0, overflowOut}, 32'd1);
        checkValue("ovf_head", dataOut, 32'h00010000);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("ovf_drain1");
        checkValue("ovf_second", dataOut, 32'h00030002);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("ovf_drain2");
        checkValue("ovf_empty", {31'd0, validOut}, 32'd0);

        $display("[TB] realign");
        applyStimulus(1'b1, 16'h5555, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h6666, 1'b1, 1'b0);
        checkOutput("ra_after");
        checkValue("ra_phase", {31'd0, phaseOut}, 32'd0);
        applyStimulus(1'b1, 16'h7777, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h8888, 1'b0, 1'b0);
        checkOutput("ra_word");
        checkValue("ra_data", dataOut, 32'h88887777);
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkOutput("ra_only_one");

        $display("[TB] random");
        for (int i = 0; i < 400; i++) begin
            v  = ($urandom_range(0, 3) != 0);
            d  = H'($urandom);
            ra = ($urandom_range(0, 19) == 0);
            y  = $urandom_range(0, 1) != 0;
            applyStimulus(v, d, ra, y);
            checkOutput("rand");
        end

        $display("[TB] reset mid-word");
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        drain();
        applyStimulus(1'b1, 16'h0A0A, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0B0B, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'h0C0C, 1'b0, 1'b0);
        checkOutput("rst_setup");
        validIn = 1'b0;
        #2;
        resetN = 1'b0;
        #1;
        checkValue("rst_valid", {31'd0, validOut}, 32'd0);
        checkValue("rst_overflow", {31'd0, overflowOut}, 32'd0);
        checkValue("rst_phase", {31'd0, phaseOut}, 32'd0);
        checkValue("rst_data", dataOut, 32'd0);
        modelReset();
        @(posedge clk);
        #1;
        resetN = 1'b1;
        checkOutput("rst_release");
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        checkOutput("rst_low");
        applyStimulus(1'b1, 16'h5678, 1'b0, 1'b0);
        checkOutput("rst_word");
        checkValue("rst_first_word", dataOut, 32'h56781234);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
